// File: rtl/pueo_trig_accept.sv
// L2 trigger receiver: stamps accepted triggers with event number and time, queues the
// records for the event builder and drives holdoff/dead back to the L2.
module pueo_trig_accept #(
    parameter int DEPTH     = 16,
    parameter int HOLD_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic                 run_i,
    input  logic [HOLD_BITS-1:0] holdoff_len_i,
    input  logic                 trig_i,
    input  logic [63:0]          tio0_meta_i,
    input  logic [63:0]          tio1_meta_i,
    input  logic [63:0]          tio2_meta_i,
    input  logic [63:0]          tio3_meta_i,
    output logic                 holdoff_o,
    output logic                 dead_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [31:0]          evt_number_o,
    output logic [31:0]          evt_time_o,
    output logic [255:0]         evt_meta_o,
    output logic [15:0]          overflow_count_o,
    output logic [15:0]          holdviol_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 320;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} hold_state_t;

    hold_state_t          state_q, state_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]          ts_q, ts_d;
    logic [31:0]          num_q, num_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [15:0]          ovf_q, ovf_d;
    logic [15:0]          hv_q, hv_d;
    logic                 dead_q, dead_d;
    logic [RW-1:0]        mem_q [DEPTH];
    logic [RW-1:0]        head;

    logic hold_active, full, trig_run, accept, pop, drop_full, drop_hold;

    // Handshake: a record transfers on any clk where evt_valid_o & evt_ready_i; the head
    // record and valid are held unchanged while valid & !ready.
    always_comb begin
        hold_active = (state_q == HOLD);
        full        = (count_q == CW'(DEPTH));
        trig_run    = trig_i & run_i;
        accept      = trig_run & ~hold_active & ~full;
        drop_hold   = trig_run & hold_active;
        drop_full   = trig_run & ~hold_active & full;
        pop         = (count_q != '0) & evt_ready_i;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && holdoff_len_i != '0) begin
                    state_d    = HOLD;
                    hold_cnt_d = holdoff_len_i;
                end
            end
            HOLD: begin
                if (ce_i) begin
                    if (hold_cnt_q == HOLD_BITS'(1)) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_BITS'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Full is judged on the pre-pop count, so a push into a full FIFO is lost even when
    // the consumer frees a slot on the same clk.
    always_comb begin
        ts_d     = ts_q + 32'(ce_i);
        num_d    = accept ? num_q + 32'd1 : num_q;
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(accept) - CW'(pop);
        ovf_d    = (drop_full && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
        hv_d     = (drop_hold && hv_q != 16'hFFFF) ? hv_q + 16'd1 : hv_q;
        // One spare slot absorbs the trigger already in flight in the L2's output register.
        dead_d   = ~run_i | (count_d >= CW'(DEPTH - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            ts_q       <= '0;
            num_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            hv_q       <= '0;
            dead_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ts_q       <= ts_d;
            num_q      <= num_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            hv_q       <= hv_d;
            dead_q     <= dead_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {num_q, ts_q, tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i};
        end
    end

    always_comb begin
        head             = mem_q[rd_ptr_q];
        evt_valid_o      = (count_q != '0);
        evt_number_o     = '0;
        evt_time_o       = '0;
        evt_meta_o       = '0;
        if (evt_valid_o) begin
            evt_number_o = head[319:288];
            evt_time_o   = head[287:256];
            evt_meta_o   = head[255:0];
        end
        holdoff_o        = hold_active;
        dead_o           = dead_q;
        overflow_count_o = ovf_q;
        holdviol_count_o = hv_q;
    end

endmodule

// File: tb/tb_pueo_trig_accept.sv
// Bench for pueo_trig_accept: queue-based event model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_pueo_trig_accept;
    localparam int DEPTH = 16;

    logic         clk_i = 1'b0;
    logic         rst_i, ce_i, run_i, trig_i, evt_ready_i;
    logic [15:0]  holdoff_len_i;
    logic [63:0]  tio0_meta_i, tio1_meta_i, tio2_meta_i, tio3_meta_i;
    logic         holdoff_o, dead_o, evt_valid_o;
    logic [31:0]  evt_number_o, evt_time_o;
    logic [255:0] evt_meta_o;
    logic [15:0]  overflow_count_o, holdviol_count_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk_i = ~clk_i;

    pueo_trig_accept #(.DEPTH(DEPTH), .HOLD_BITS(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ce_i             (ce_i),
        .run_i            (run_i),
        .holdoff_len_i    (holdoff_len_i),
        .trig_i           (trig_i),
        .tio0_meta_i      (tio0_meta_i),
        .tio1_meta_i      (tio1_meta_i),
        .tio2_meta_i      (tio2_meta_i),
        .tio3_meta_i      (tio3_meta_i),
        .holdoff_o        (holdoff_o),
        .dead_o           (dead_o),
        .evt_valid_o      (evt_valid_o),
        .evt_ready_i      (evt_ready_i),
        .evt_number_o     (evt_number_o),
        .evt_time_o       (evt_time_o),
        .evt_meta_o       (evt_meta_o),
        .overflow_count_o (overflow_count_o),
        .holdviol_count_o (holdviol_count_o)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event model: a queue of {number, time, meta} records, remaining holdoff in ce ticks.
    logic [319:0] exp_q[$];
    logic [31:0]  m_num, m_ts;
    logic [15:0]  m_ovf, m_hv;
    int           m_hold_left;
    logic         m_dead;

    always @(posedge clk_i) begin : model
        int sz;
        bit acc, do_pop;
        if (rst_i) begin
            exp_q.delete();
            m_num = 0; m_ts = 0; m_ovf = 0; m_hv = 0; m_hold_left = 0; m_dead = 1'b1;
        end else begin
            sz     = exp_q.size();
            do_pop = (sz > 0) && evt_ready_i;
            acc    = 1'b0;
            if (trig_i && run_i) begin
                if (m_hold_left > 0) begin
                    if (m_hv != 16'hFFFF) m_hv++;
                end else if (sz >= DEPTH) begin
                    if (m_ovf != 16'hFFFF) m_ovf++;
                end else begin
                    acc = 1'b1;
                end
            end
            if (m_hold_left > 0 && ce_i) m_hold_left--;
            if (do_pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({m_num, m_ts, tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i});
                m_num++;
                m_hold_left = int'(holdoff_len_i);
            end
            if (ce_i) m_ts++;
            m_dead = !run_i || (exp_q.size() >= DEPTH - 1);
        end
    end

    always @(negedge clk_i) begin : compare
        logic [319:0] f;
        if (chk_en) begin
            f = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("evt_valid", 256'(evt_valid_o), 256'(exp_q.size() > 0));
            check("evt_number", 256'(evt_number_o), 256'(f[319:288]));
            check("evt_time", 256'(evt_time_o), 256'(f[287:256]));
            check("evt_meta", evt_meta_o, f[255:0]);
            check("holdoff", 256'(holdoff_o), 256'(m_hold_left > 0));
            check("dead", 256'(dead_o), 256'(m_dead));
            check("overflow_count", 256'(overflow_count_o), 256'(m_ovf));
            check("holdviol_count", 256'(holdviol_count_o), 256'(m_hv));
        end
    end

    // ce_i toggles every clk, giving a ce on every 2nd clk; trig_i is a one-clk pulse.
    task automatic tick();
        @(posedge clk_i);
        #1;
        ce_i   = ~ce_i;
        trig_i = 1'b0;
    endtask

    task automatic trig_ce(input logic [63:0] base);
        tick();
        if (!ce_i) tick();
        trig_i      = 1'b1;
        tio0_meta_i = base + 64'd1;
        tio1_meta_i = base + 64'd2;
        tio2_meta_i = base + 64'd3;
        tio3_meta_i = base + 64'd4;
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int hcnt;
        int n;
        rst_i = 1'b1; ce_i = 1'b0; run_i = 1'b0; trig_i = 1'b0; evt_ready_i = 1'b0;
        holdoff_len_i = 16'd0;
        tio0_meta_i = '0; tio1_meta_i = '0; tio2_meta_i = '0; tio3_meta_i = '0;
        tick();
        chk_en = 1'b1;
        @(negedge clk_i);
        check("rst_dead", 256'(dead_o), 256'(1));
        check("rst_valid", 256'(evt_valid_o), 256'(0));
        check("rst_holdoff", 256'(holdoff_o), 256'(0));
        check("rst_overflow", 256'(overflow_count_o), 256'(0));
        tick();
        rst_i = 1'b0;
        run_i = 1'b1;

        // 1: single trigger with a 4-tick holdoff
        holdoff_len_i = 16'd4;
        trig_ce(64'd0);
        @(negedge clk_i);
        check("t1_valid", 256'(evt_valid_o), 256'(1));
        check("t1_number", 256'(evt_number_o), 256'd0);
        check("t1_meta", evt_meta_o, {64'd4, 64'd3, 64'd2, 64'd1});
        check("t1_dead", 256'(dead_o), 256'(0));
        hcnt = 0;
        repeat (20) begin
            if (holdoff_o) hcnt++;
            tick();
            @(negedge clk_i);
        end
        check("t1_holdoff_clks", 256'(hcnt), 256'd8);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;

        // 2: fill with no consumer
        holdoff_len_i = 16'd0;
        for (int i = 0; i < 15; i++) begin
            trig_ce(64'(i * 16));
            @(negedge clk_i);
            if (i == 13) check("t2_dead_after14", 256'(dead_o), 256'(0));
            if (i == 14) check("t2_dead_after15", 256'(dead_o), 256'(1));
        end
        trig_ce(64'h100);
        trig_ce(64'h200);
        @(negedge clk_i);
        check("t2_overflow", 256'(overflow_count_o), 256'd1);
        check("t2_head_number", 256'(evt_number_o), 256'd1);

        // 3: full FIFO, trigger and pop on the same clk
        tick();
        if (!ce_i) tick();
        trig_i = 1'b1;
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        @(negedge clk_i);
        check("t3_overflow", 256'(overflow_count_o), 256'd2);
        n = 0;
        evt_ready_i = 1'b1;
        repeat (40) begin
            if (evt_valid_o) n++;
            tick();
            @(negedge clk_i);
        end
        evt_ready_i = 1'b0;
        check("t3_records_left", 256'(n), 256'd15);
        check("t3_dead_drained", 256'(dead_o), 256'(0));

        // 4: trigger during holdoff
        holdoff_len_i = 16'd4;
        trig_ce(64'h300);
        trig_ce(64'h400);
        @(negedge clk_i);
        check("t4_holdviol", 256'(holdviol_count_o), 256'd1);
        check("t4_head_number", 256'(evt_number_o), 256'd17);
        repeat (12) tick();
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        holdoff_len_i = 16'd0;
        trig_ce(64'h500);
        @(negedge clk_i);
        check("t4_next_number", 256'(evt_number_o), 256'd18);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;

        // 5: run disabled
        run_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("t5_dead_norun", 256'(dead_o), 256'(1));
        trig_ce(64'h600);
        trig_ce(64'h700);
        @(negedge clk_i);
        check("t5_no_record", 256'(evt_valid_o), 256'(0));
        tick();
        run_i = 1'b1;
        @(negedge clk_i);
        check("t5_dead_same_clk", 256'(dead_o), 256'(1));
        tick();
        @(negedge clk_i);
        check("t5_dead_released", 256'(dead_o), 256'(0));

        // 6: reset with records queued and holdoff active
        trig_ce(64'h800);
        trig_ce(64'h900);
        holdoff_len_i = 16'd8;
        trig_ce(64'hA00);
        tick();
        @(negedge clk_i);
        check("t6_holding", 256'(holdoff_o), 256'(1));
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t6_valid", 256'(evt_valid_o), 256'(0));
        check("t6_holdoff", 256'(holdoff_o), 256'(0));
        check("t6_overflow", 256'(overflow_count_o), 256'd0);
        check("t6_holdviol", 256'(holdviol_count_o), 256'd0);
        check("t6_dead", 256'(dead_o), 256'(1));
        holdoff_len_i = 16'd0;
        trig_ce(64'hB00);
        @(negedge clk_i);
        check("t6_number_restart", 256'(evt_number_o), 256'd0);
        evt_ready_i = 1'b1;
        repeat (4) tick();
        evt_ready_i = 1'b0;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
